// File: rtl/syn_sram_gpu_resp.sv
// GPU pixel port to 16-bit asynchronous SRAM bridge.
// Each 16-bit SRAM word holds two pixels. Address bit 0 selects the byte lane:
// 0 selects the low byte, 1 selects the high byte.
// Each request takes a fixed 3-cycle access (setup + pulse, or access + capture).
// Every output is registered. Next-state values are derived from state_d.
//
// Ports:
//   clk_ir, rst_sync   clock, synchronous active-high reset
//   gpu_*              pixel request/response port (rdy/valid handshake)
//   oor_cnt            saturating count of accepted out-of-range requests
//   sram_*             SRAM pins (active-low strobes, split data bus with oe)
module syn_sram_gpu_resp #(
  parameter int unsigned P_GPU_SRAM_ADDR_W = 19,
  parameter int unsigned P_SRAM_ADDR_W     = 18,
  parameter int unsigned P_PXL_W           = 8,
  parameter int unsigned P_PXL_MAX         = 307200
) (
  input  logic                         clk_ir,
  input  logic                         rst_sync,
  // GPU side
  input  logic [P_GPU_SRAM_ADDR_W-1:0] gpu_addr,
  input  logic                         gpu_rd_en,
  input  logic                         gpu_wr_en,
  input  logic [P_PXL_W-1:0]           gpu_wr_data,
  output logic                         gpu_rdy,
  output logic                         gpu_rd_valid,
  output logic [P_PXL_W-1:0]           gpu_rd_data,
  output logic [15:0]                  oor_cnt,
  // SRAM side
  output logic [P_SRAM_ADDR_W-1:0]     sram_addr,
  output logic [15:0]                  sram_dq_o,
  input  logic [15:0]                  sram_dq_i,
  output logic                         sram_dq_oe,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic                         sram_lb_n,
  output logic                         sram_ub_n
);

  typedef enum logic [2:0] {StIdle, StWrSetup, StWrPulse, StRdAcc, StRdCap} state_e;

  state_e                   state_q, state_d;
  logic                     lsb_q, lsb_d;   // byte lane of the access in flight
  logic                     oor_q, oor_d;   // access in flight is out of range
  logic                     rdy_q, rdy_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [P_PXL_W-1:0]       rd_data_q, rd_data_d;
  logic [15:0]              oor_cnt_q, oor_cnt_d;
  logic [P_SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]              dq_o_q, dq_o_d;
  logic                     dq_oe_q, dq_oe_d;
  logic                     ce_n_q, ce_n_d;
  logic                     oe_n_q, oe_n_d;
  logic                     we_n_q, we_n_d;
  logic                     lb_n_q, lb_n_d;
  logic                     ub_n_q, ub_n_d;

  logic accept;
  logic req_oor;

  assign accept  = (state_q == StIdle) && rdy_q && (gpu_rd_en || gpu_wr_en);
  assign req_oor = 32'(gpu_addr) >= P_PXL_MAX;

  always_comb begin
    state_d    = state_q;
    lsb_d      = lsb_q;
    oor_d      = oor_q;
    addr_d     = addr_q;
    dq_o_d     = dq_o_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    oor_cnt_d  = oor_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // A simultaneous read+write request is serviced as a write only.
          state_d = gpu_wr_en ? StWrSetup : StRdAcc;
          lsb_d   = gpu_addr[0];
          oor_d   = req_oor;
          addr_d  = P_SRAM_ADDR_W'(gpu_addr >> 1);
          dq_o_d  = gpu_addr[0] ? (16'(gpu_wr_data) << 8) : 16'(gpu_wr_data);
          if (req_oor && (oor_cnt_q != 16'hFFFF)) begin
            oor_cnt_d = oor_cnt_q + 16'd1;
          end
        end
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: state_d = StIdle;
      StRdAcc:   state_d = StRdCap;
      StRdCap: begin
        state_d    = StIdle;
        rd_valid_d = 1'b1;
        if (oor_q) begin
          rd_data_d = '0;
        end else begin
          rd_data_d = lsb_q ? P_PXL_W'(sram_dq_i[15:8]) : P_PXL_W'(sram_dq_i[7:0]);
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin values for the cycle that follows, decoded from the next state.
    rdy_d   = (state_d == StIdle);
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    unique case (state_d)
      StWrSetup, StWrPulse: begin
        ce_n_d  = oor_d;
        we_n_d  = (state_d != StWrPulse) || oor_d;
        dq_oe_d = 1'b1;
        lb_n_d  = lsb_d;
        ub_n_d  = ~lsb_d;
      end
      StRdAcc, StRdCap: begin
        ce_n_d = oor_d;
        oe_n_d = oor_d;
        lb_n_d = lsb_d;
        ub_n_d = ~lsb_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state_q    <= StIdle;
      lsb_q      <= 1'b0;
      oor_q      <= 1'b0;
      rdy_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      oor_cnt_q  <= '0;
      addr_q     <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lsb_q      <= lsb_d;
      oor_q      <= oor_d;
      rdy_q      <= rdy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      oor_cnt_q  <= oor_cnt_d;
      addr_q     <= addr_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      lb_n_q     <= lb_n_d;
      ub_n_q     <= ub_n_d;
    end
  end

  assign gpu_rdy      = rdy_q;
  assign gpu_rd_valid = rd_valid_q;
  assign gpu_rd_data  = rd_data_q;
  assign oor_cnt      = oor_cnt_q;
  assign sram_addr    = addr_q;
  assign sram_dq_o    = dq_o_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_lb_n    = lb_n_q;
  assign sram_ub_n    = ub_n_q;

endmodule

// File: tb/tb_syn_sram_gpu_resp.sv
// Directed bench for syn_sram_gpu_resp.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_syn_sram_gpu_resp;

  logic        clk_ir = 1'b0;
  logic        rst_sync;
  logic [18:0] gpu_addr;
  logic        gpu_rd_en;
  logic        gpu_wr_en;
  logic [7:0]  gpu_wr_data;
  logic        gpu_rdy;
  logic        gpu_rd_valid;
  logic [7:0]  gpu_rd_data;
  logic [15:0] oor_cnt;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_lb_n;
  logic        sram_ub_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_ir = ~clk_ir;

  syn_sram_gpu_resp dut (
    .clk_ir       (clk_ir),
    .rst_sync     (rst_sync),
    .gpu_addr     (gpu_addr),
    .gpu_rd_en    (gpu_rd_en),
    .gpu_wr_en    (gpu_wr_en),
    .gpu_wr_data  (gpu_wr_data),
    .gpu_rdy      (gpu_rdy),
    .gpu_rd_valid (gpu_rd_valid),
    .gpu_rd_data  (gpu_rd_data),
    .oor_cnt      (oor_cnt),
    .sram_addr    (sram_addr),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_oe   (sram_dq_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_lb_n    (sram_lb_n),
    .sram_ub_n    (sram_ub_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_ir);
  endtask

  // Outputs expected while no access is in flight.
  task automatic check_idle(input string tag);
    check_eq({tag, " rdy"}, 32'(gpu_rdy), 32'd1);
    check_eq({tag, " ce_n"}, 32'(sram_ce_n), 32'd1);
    check_eq({tag, " oe_n"}, 32'(sram_oe_n), 32'd1);
    check_eq({tag, " we_n"}, 32'(sram_we_n), 32'd1);
    check_eq({tag, " dq_oe"}, 32'(sram_dq_oe), 32'd0);
  endtask

  logic [18:0] rd_addr [3];
  logic [15:0] rd_dq   [3];
  logic [7:0]  rd_exp  [3];

  initial begin
    rd_addr[0] = 19'h00100; rd_dq[0] = 16'h1234; rd_exp[0] = 8'h34;
    rd_addr[1] = 19'h00101; rd_dq[1] = 16'hBEEF; rd_exp[1] = 8'hBE;
    rd_addr[2] = 19'h00102; rd_dq[2] = 16'h0F0E; rd_exp[2] = 8'h0E;

    rst_sync    = 1'b1;
    gpu_addr    = '0;
    gpu_rd_en   = 1'b0;
    gpu_wr_en   = 1'b1;  // a request held during reset must be ignored
    gpu_wr_data = 8'hFF;
    sram_dq_i   = 16'h3C5A;
    repeat (3) step();

    // Reset state
    check_eq("rst rdy", 32'(gpu_rdy), 32'd0);
    check_eq("rst rd_valid", 32'(gpu_rd_valid), 32'd0);
    check_eq("rst rd_data", 32'(gpu_rd_data), 32'd0);
    check_eq("rst oor_cnt", 32'(oor_cnt), 32'd0);
    check_eq("rst sram_addr", 32'(sram_addr), 32'd0);
    check_eq("rst dq_o", 32'(sram_dq_o), 32'd0);
    check_eq("rst dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("rst ce/oe/we/lb/ub", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}),
             32'h1F);
    gpu_wr_en = 1'b0;
    rst_sync  = 1'b0;
    step();
    check_eq("rdy after release", 32'(gpu_rdy), 32'd1);

    // Write 0xA7 to pixel 5: high lane of word 2
    gpu_addr = 19'h00005; gpu_wr_data = 8'hA7; gpu_wr_en = 1'b1;
    step();
    gpu_wr_en = 1'b0;
    check_eq("wr1 setup rdy", 32'(gpu_rdy), 32'd0);
    check_eq("wr1 sram_addr", 32'(sram_addr), 32'h00002);
    check_eq("wr1 lanes ub/lb", 32'({sram_ub_n, sram_lb_n}), 32'b01);
    check_eq("wr1 dq_o", 32'(sram_dq_o), 32'hA700);
    check_eq("wr1 setup ce_n", 32'(sram_ce_n), 32'd0);
    check_eq("wr1 setup dq_oe", 32'(sram_dq_oe), 32'd1);
    check_eq("wr1 setup oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("wr1 setup we_n", 32'(sram_we_n), 32'd1);
    step();
    check_eq("wr1 pulse we_n", 32'(sram_we_n), 32'd0);
    check_eq("wr1 pulse rdy", 32'(gpu_rdy), 32'd0);
    check_eq("wr1 pulse ce_n", 32'(sram_ce_n), 32'd0);
    step();
    check_idle("wr1 done");

    // Read pixel 4: low lane of word 2
    gpu_addr = 19'h00004; gpu_rd_en = 1'b1;
    step();
    gpu_rd_en = 1'b0;
    check_eq("rd1 acc oe_n", 32'(sram_oe_n), 32'd0);
    check_eq("rd1 acc ce_n", 32'(sram_ce_n), 32'd0);
    check_eq("rd1 acc dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("rd1 sram_addr", 32'(sram_addr), 32'h00002);
    check_eq("rd1 lanes ub/lb", 32'({sram_ub_n, sram_lb_n}), 32'b10);
    check_eq("rd1 acc valid", 32'(gpu_rd_valid), 32'd0);
    step();
    check_eq("rd1 cap oe_n", 32'(sram_oe_n), 32'd0);
    check_eq("rd1 cap dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("rd1 cap valid", 32'(gpu_rd_valid), 32'd0);
    step();
    check_eq("rd1 valid T+3", 32'(gpu_rd_valid), 32'd1);
    check_eq("rd1 data", 32'(gpu_rd_data), 32'h5A);
    check_idle("rd1 done");
    step();
    check_eq("rd1 valid single", 32'(gpu_rd_valid), 32'd0);
    check_eq("rd1 data held", 32'(gpu_rd_data), 32'h5A);

    // Out-of-range read: no strobes, zero data, normal latency
    gpu_addr = 19'd307200; gpu_rd_en = 1'b1;
    step();
    gpu_rd_en = 1'b0;
    check_eq("oor acc ce_n", 32'(sram_ce_n), 32'd1);
    check_eq("oor acc oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("oor cnt", 32'(oor_cnt), 32'd1);
    check_eq("oor acc rdy", 32'(gpu_rdy), 32'd0);
    step();
    check_eq("oor cap ce_n", 32'(sram_ce_n), 32'd1);
    check_eq("oor cap valid", 32'(gpu_rd_valid), 32'd0);
    step();
    check_eq("oor valid T+3", 32'(gpu_rd_valid), 32'd1);
    check_eq("oor data", 32'(gpu_rd_data), 32'h00);

    // Read and write together: serviced as a write only
    gpu_addr = 19'd10; gpu_wr_data = 8'h11; gpu_rd_en = 1'b1; gpu_wr_en = 1'b1;
    step();
    gpu_rd_en = 1'b0; gpu_wr_en = 1'b0;
    check_eq("rw sram_addr", 32'(sram_addr), 32'd5);
    check_eq("rw lanes ub/lb", 32'({sram_ub_n, sram_lb_n}), 32'b10);
    check_eq("rw dq_o", 32'(sram_dq_o), 32'h0011);
    check_eq("rw dq_oe", 32'(sram_dq_oe), 32'd1);
    check_eq("rw oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("rw valid c1", 32'(gpu_rd_valid), 32'd0);
    step();
    check_eq("rw we_n", 32'(sram_we_n), 32'd0);
    check_eq("rw valid c2", 32'(gpu_rd_valid), 32'd0);
    step();
    check_eq("rw valid c3", 32'(gpu_rd_valid), 32'd0);
    check_eq("rw oor cnt unchanged", 32'(oor_cnt), 32'd1);
    step();
    check_eq("rw valid c4", 32'(gpu_rd_valid), 32'd0);

    // Back-to-back reads with gpu_rd_en held: accepts every third edge
    gpu_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gpu_addr  = rd_addr[i];
      sram_dq_i = rd_dq[i];
      step();
      check_eq($sformatf("b2b%0d sram_addr", i), 32'(sram_addr), 32'(rd_addr[i] >> 1));
      check_eq($sformatf("b2b%0d rdy c1", i), 32'(gpu_rdy), 32'd0);
      check_eq($sformatf("b2b%0d valid c1", i), 32'(gpu_rd_valid), 32'd0);
      step();
      check_eq($sformatf("b2b%0d valid c2", i), 32'(gpu_rd_valid), 32'd0);
      step();
      check_eq($sformatf("b2b%0d valid c3", i), 32'(gpu_rd_valid), 32'd1);
      check_eq($sformatf("b2b%0d data", i), 32'(gpu_rd_data), 32'(rd_exp[i]));
      check_eq($sformatf("b2b%0d rdy c3", i), 32'(gpu_rdy), 32'd1);
    end
    gpu_rd_en = 1'b0;
    sram_dq_i = 16'h3C5A;
    step();

    // Reset during the write pulse
    gpu_addr = 19'd6; gpu_wr_data = 8'h55; gpu_wr_en = 1'b1;
    step();
    gpu_wr_en = 1'b0;
    step();
    check_eq("abw pulse we_n", 32'(sram_we_n), 32'd0);
    rst_sync = 1'b1;
    step();
    check_eq("abw we_n", 32'(sram_we_n), 32'd1);
    check_eq("abw ce_n", 32'(sram_ce_n), 32'd1);
    check_eq("abw dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("abw rdy", 32'(gpu_rdy), 32'd0);
    check_eq("abw oor cnt cleared", 32'(oor_cnt), 32'd0);
    rst_sync = 1'b0;
    step();
    check_eq("abw rdy after release", 32'(gpu_rdy), 32'd1);

    // Reset during a read access: no valid for the aborted read
    gpu_addr = 19'd8; gpu_rd_en = 1'b1;
    step();
    gpu_rd_en = 1'b0;
    check_eq("abr acc oe_n", 32'(sram_oe_n), 32'd0);
    rst_sync = 1'b1;
    step();
    check_eq("abr oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("abr valid", 32'(gpu_rd_valid), 32'd0);
    rst_sync = 1'b0;
    step();
    check_eq("abr valid after", 32'(gpu_rd_valid), 32'd0);
    check_eq("abr rdy after release", 32'(gpu_rdy), 32'd1);
    step();
    check_eq("abr no late valid", 32'(gpu_rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_sram_gpu_resp.md
SYN_SRAM_GPU_RESP -- requirements
Module: syn_sram_gpu_resp

Interface
REQ-001 SHALL have parameter P_GPU_SRAM_ADDR_W, default 19, giving the pixel address width.
REQ-002 SHALL have parameter P_SRAM_ADDR_W, default 18, giving the SRAM word address width.
REQ-003 SHALL have parameter P_PXL_W, default 8, giving the pixel width.
REQ-004 SHALL have parameter P_PXL_MAX, default 307200, giving the number of valid pixels (640x480).
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
- clk_ir  in  1  clock
- rst_sync  in  1  synchronous active-high reset
REQ-006 GPU port:
- gpu_addr  in  P_GPU_SRAM_ADDR_W  pixel address
- gpu_rd_en  in  1  read request
- gpu_wr_en  in  1  write request
- gpu_wr_data  in  P_PXL_W  write pixel
- gpu_rdy  out  1  ready to accept
- gpu_rd_valid  out  1  read data strobe
- gpu_rd_data  out  P_PXL_W  read pixel
- oor_cnt  out  16  out-of-range request count
REQ-007 SRAM port:
- sram_addr  out  P_SRAM_ADDR_W  word address
- sram_dq_o  out  16  write data
- sram_dq_i  in  16  read data
- sram_dq_oe  out  1  data bus drive enable
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_lb_n  out  1  low byte lane enable, active low
- sram_ub_n  out  1  high byte lane enable, active low

Function
REQ-008 SHALL drive every SRAM-side output and gpu_rdy, gpu_rd_valid, gpu_rd_data from registers, with no combinational path from inputs to outputs.
REQ-009 SHALL accept a request on a clk_ir edge where gpu_rdy=1 and (gpu_rd_en|gpu_wr_en)=1, registering the address, the data and the request type.
REQ-010 SHALL treat a request with gpu_rd_en and gpu_wr_en both high as a write only, emitting no gpu_rd_valid for it.
REQ-011 SHALL implement the FSM states IDLE, WR_SETUP, WR_PULSE, RD_ACC and RD_CAP.
- IDLE: on write accept go to WR_SETUP; on read accept go to RD_ACC.
- WR_SETUP goes to WR_PULSE.
- WR_PULSE goes to IDLE.
- RD_ACC goes to RD_CAP.
- RD_CAP goes to IDLE.
REQ-012 SHALL assert gpu_rdy only in IDLE, so throughput is at most one request per 3 cycles.
REQ-013 SHALL map the word address as sram_addr = addr[P_GPU_SRAM_ADDR_W-1:1], with lane selection:
- addr[0]=0: lb_n=0, ub_n=1.
- addr[0]=1: ub_n=0, lb_n=1.
REQ-014 Write access:
- WR_SETUP and WR_PULSE: ce_n=0, dq_oe=1, oe_n=1.
- sram_dq_o = pixel replicated into the selected lane, with the other lane 0.
- we_n=0 only in WR_PULSE, exactly 1 cycle.
REQ-015 Read access:
- RD_ACC and RD_CAP: ce_n=0, oe_n=0, dq_oe=0.
- SHALL capture sram_dq_i on the edge leaving RD_CAP.
- gpu_rd_data = dq_i[15:8] if addr[0]=1, else dq_i[7:0].
- gpu_rd_valid=1 for exactly 1 cycle, 3 cycles after the accept edge (accept at T gives valid at T+3).
REQ-016 SHALL hold gpu_rd_data until the next gpu_rd_valid.
REQ-017 Out-of-range request (addr >= P_PXL_MAX):
- SHALL still traverse the normal states.
- ce_n, we_n and oe_n SHALL stay at 1.
- A read SHALL return gpu_rd_data=0 with normal latency.
- oor_cnt SHALL increment on accept and saturate at 16'hFFFF.
REQ-018 In states other than those above, SHALL drive ce_n=we_n=oe_n=lb_n=ub_n=1 and dq_oe=0.
REQ-019 SHALL never assert dq_oe and oe_n=0 in the same cycle.

Reset
REQ-020 With rst_sync=1 at an edge, SHALL set:
- state=IDLE.
- gpu_rdy=0, gpu_rd_valid=0, gpu_rd_data=0, oor_cnt=0.
- sram_addr=0, sram_dq_o=0, dq_oe=0.
- ce_n=oe_n=we_n=lb_n=ub_n=1.
REQ-021 SHALL ignore requests while rst_sync=1, and SHALL raise gpu_rdy on the first edge after rst_sync falls.
REQ-022 Reset mid-access SHALL abort the access:
- All strobes SHALL be released at that same edge.
- No gpu_rd_valid SHALL be emitted for the aborted read.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write addr 0x00005, data 0xA7 -> sram_addr=0x00002, ub_n=0, lb_n=1, dq_o=0xA700, we_n low exactly 1 cycle, gpu_rdy low 2 cycles.
- Read addr 0x00004 with sram_dq_i=0x3C5A -> gpu_rd_data=0x5A, gpu_rd_valid one cycle at T+3, oe_n low 2 cycles, dq_oe=0 throughout.
- Read addr 307200 -> ce_n stays 1, gpu_rd_valid at T+3 with data 0x00, oor_cnt=1.
- gpu_rd_en=gpu_wr_en=1, addr 10, data 0x11 -> write to sram_addr=5 with lb_n=0, dq_o=0x0011, no gpu_rd_valid.
- gpu_rd_en held high with 3 different addresses -> accepts at T, T+3, T+6, rd_valid at T+3, T+6, T+9 with the correct lane data.
- rst_sync pulsed during WR_PULSE -> next edge we_n=1, ce_n=1, dq_oe=0, gpu_rdy=0; gpu_rdy=1 one cycle after release.
